// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced start/clear/lap buttons drive an IDLE/RUN/STOP/LAP FSM producing CE, CLR and HOLD.
// Latency: a clean raw button edge reaches CE/state DEB_CYCLES+3 CLK edges later; CLR starts the cycle after a clear event.
// Backpressure: none; buttons are free-running levels and outputs are unconditional registered levels.
// Optional lap feature: define STOPWATCH_LAP_EN to build the lap debouncer and make the LAP state reachable.

// Per-button conditioning: 2-flop synchronizer, counting debouncer, rising-edge press pulse.
module stopwatch_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    logic        sync_1;
    logic        sync_2;
    logic        level;
    logic        level_d;
    logic [15:0] deb_cnt;

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Count consecutive samples that disagree with the accepted level; accept the new level
    // once DEB_CYCLES disagreeing samples in a row have been seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level   <= 1'b0;
            deb_cnt <= 16'd0;
        end else if (sync_2 == level) begin
            deb_cnt <= 16'd0;
        end else if (deb_cnt == DEB_LAST) begin
            level   <= sync_2;
            deb_cnt <= 16'd0;
        end else begin
            deb_cnt <= deb_cnt + 16'd1;
        end
    end

    // Delayed copy of the debounced level for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    // One-cycle press event on the debounced rising edge only; releases produce nothing.
    assign press = level & ~level_d;

endmodule

module stopwatch_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int CLR_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       btnStart,
    input  logic       btnClear,
    input  logic       btnLap,
    output logic       CE,
    output logic       CLR,
    output logic       HOLD,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STOP = 2'b10,
        LAP  = 2'b11
    } state_t;

    // CLR is already high on the load cycle, so the counter holds the remaining extra cycles.
    localparam logic [7:0] CLR_LOAD = 8'(CLR_CYCLES - 1);

    state_t     cur_state;
    state_t     nxt_state;
    logic       start_ev;
    logic       clear_ev;
    logic       lap_ev;
    logic       clr_fire;
    logic [7:0] clr_cnt;

    stopwatch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (CLK),
        .rst   (R),
        .btn   (btnStart),
        .press (start_ev)
    );

    stopwatch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .clk   (CLK),
        .rst   (R),
        .btn   (btnClear),
        .press (clear_ev)
    );

`ifdef STOPWATCH_LAP_EN
    stopwatch_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
        .clk   (CLK),
        .rst   (R),
        .btn   (btnLap),
        .press (lap_ev)
    );
`else
    // Lap button is not conditioned in this build; the name keeps the dangling input quiet.
    logic lap_unused;
    assign lap_unused = btnLap;
    assign lap_ev     = 1'b0;
`endif

    // Next-state decode; start beats clear beats lap, and a losing event in the same cycle is dropped.
    always_comb begin
        nxt_state = cur_state;
        clr_fire  = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start_ev) begin
                    nxt_state = RUN;
                end else if (clear_ev) begin
                    clr_fire = 1'b1;
                end
            end
            RUN: begin
                if (start_ev) begin
                    nxt_state = STOP;
                end else if (lap_ev) begin
                    nxt_state = LAP;
                end
            end
            STOP: begin
                if (start_ev) begin
                    nxt_state = RUN;
                end else if (clear_ev) begin
                    nxt_state = IDLE;
                    clr_fire  = 1'b1;
                end
            end
            LAP: begin
`ifdef STOPWATCH_LAP_EN
                if (start_ev) begin
                    nxt_state = STOP;
                end else if (lap_ev) begin
                    nxt_state = RUN;
                end
`else
                // LAP cannot be entered without the lap feature; fall back to IDLE.
                nxt_state = IDLE;
`endif
            end
            default: begin
                nxt_state = IDLE;
            end
        endcase
    end

    // State register plus CE/HOLD registered from the next state so they change with it.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            cur_state <= IDLE;
            CE        <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            CE        <= (nxt_state == RUN) || (nxt_state == LAP);
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Display freeze follows the LAP state.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            HOLD <= 1'b0;
        end else begin
            HOLD <= (nxt_state == LAP);
        end
    end
`else
    assign HOLD = 1'b0;
`endif

    // CLR pulse stretcher: a clear event (re)loads the down-counter, CLR stays high until it drains.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            clr_cnt <= 8'd0;
            CLR     <= 1'b0;
        end else if (clr_fire) begin
            clr_cnt <= CLR_LOAD;
            CLR     <= 1'b1;
        end else if (clr_cnt != 8'd0) begin
            clr_cnt <= clr_cnt - 8'd1;
            CLR     <= 1'b1;
        end else begin
            CLR     <= 1'b0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam int DEB   = 4;
    localparam int CLR_N = 3;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_STOP = 2'b10;
    localparam logic [1:0] S_LAP  = 2'b11;

    logic       CLK;
    logic       R;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic       CE;
    logic       CLR;
    logic       HOLD;
    logic [1:0] state;

    int checks;
    int errors;

    stopwatch_ctrl #(.DEB_CYCLES(DEB), .CLR_CYCLES(CLR_N)) dut (
        .CLK      (CLK),
        .R        (R),
        .btnStart (btn_start),
        .btnClear (btn_clear),
        .btnLap   (btn_lap),
        .CE       (CE),
        .CLR      (CLR),
        .HOLD     (HOLD),
        .state    (state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: raw -> two sample delays -> level accepted once the last DEB samples all
    // disagree with it -> rising edge is an event -> event-driven stopwatch rules.
    logic           m_s1   [3];
    logic           m_s2   [3];
    logic           m_deb  [3];
    logic           m_debp [3];
    logic [DEB-1:0] m_win  [3];
    logic [1:0]     m_state;
    int             m_clr_left;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b]   = 1'b0;
            m_s2[b]   = 1'b0;
            m_deb[b]  = 1'b0;
            m_debp[b] = 1'b0;
            m_win[b]  = '0;
        end
        m_state    = S_IDLE;
        m_clr_left = 0;
    endtask

    task automatic model_edge();
        logic ev [3];
        logic raw [3];
        raw[0] = btn_start;
        raw[1] = btn_clear;
        raw[2] = btn_lap;
        for (int b = 0; b < 3; b++) ev[b] = m_deb[b] & ~m_debp[b];
        if (!LAP_EN) ev[2] = 1'b0;

        if (ev[0]) begin
            // start toggles running: anything running stops, anything stopped runs
            m_state = (m_state == S_RUN || m_state == S_LAP) ? S_STOP : S_RUN;
            if (m_clr_left > 0) m_clr_left--;
        end else if (ev[1] && (m_state == S_IDLE || m_state == S_STOP)) begin
            m_state    = S_IDLE;
            m_clr_left = CLR_N;
        end else begin
            if (ev[2] && m_state == S_RUN) m_state = S_LAP;
            else if (ev[2] && m_state == S_LAP) m_state = S_RUN;
            if (m_clr_left > 0) m_clr_left--;
        end

        for (int b = 0; b < 3; b++) begin
            m_debp[b] = m_deb[b];
            m_win[b]  = {m_win[b][DEB-2:0], m_s2[b]};
            if (m_win[b] == {DEB{~m_deb[b]}}) m_deb[b] = ~m_deb[b];
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("state", state, m_state);
        chk("ce", {1'b0, CE}, {1'b0, (m_state == S_RUN) || (m_state == S_LAP)});
        chk("clr", {1'b0, CLR}, {1'b0, m_clr_left > 0});
        chk("hold", {1'b0, HOLD}, {1'b0, LAP_EN && (m_state == S_LAP)});
    endtask

    // One clock: advance the model at the edge, compare 1 time unit later.
    task automatic tick();
        @(posedge CLK);
        if (R) model_reset();
        else model_edge();
        #1;
        chk_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input int b, input int hold_n, input int settle_n);
        if (b == 0) btn_start = 1'b1;
        else if (b == 1) btn_clear = 1'b1;
        else btn_lap = 1'b1;
        ticks(hold_n);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        ticks(settle_n);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic clr_seen;
        int   rem [3];
        logic lvl [3];
        checks    = 0;
        errors    = 0;
        R         = 1'b1;
        btn_start = 1'b0;
        btn_clear = 1'b0;
        btn_lap   = 1'b0;
        model_reset();
        #1;
        chk("rst_state", state, S_IDLE);
        chk("rst_ce", {1'b0, CE}, 2'd0);
        chk("rst_clr", {1'b0, CLR}, 2'd0);
        chk("rst_hold", {1'b0, HOLD}, 2'd0);
        ticks(2);
        R = 1'b0;
        ticks(3);

        // Clean start press: CE rises on the 7th edge.
        btn_start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) chk("lat_ce_pre", {1'b0, CE}, 2'd0);
            if (k == 7) chk("lat_ce", {1'b0, CE}, 2'd1);
            if (k == 7) chk("lat_state", state, S_RUN);
        end
        btn_start = 1'b0;
        ticks(10);

        // Bouncing start: one event only, 7 edges after the final rise.
        for (int i = 0; i < 19; i++) begin
            btn_start = (i % 2 == 1);
            tick();
        end
        btn_start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) chk("bounce_ce_pre", {1'b0, CE}, 2'd1);
            if (k == 7) chk("bounce_ce", {1'b0, CE}, 2'd0);
        end
        ticks(12);
        chk("bounce_state", state, S_STOP);
        btn_start = 1'b0;
        ticks(10);

        // Clear from STOP: three CLR cycles starting edge 7, back to IDLE, CE low.
        btn_clear = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("clr_ce", {1'b0, CE}, 2'd0);
            if (k == 6 || k == 10) chk("clr_off", {1'b0, CLR}, 2'd0);
            if (k >= 7 && k <= 9) chk("clr_on", {1'b0, CLR}, 2'd1);
            if (k == 7) chk("clr_state", state, S_IDLE);
        end
        btn_clear = 1'b0;
        ticks(10);

        // Run, then lap twice.
        press(0, 8, 10);
        chk("run_state", state, S_RUN);
        press(2, 8, 10);
        chk("lap1_state", state, LAP_EN ? S_LAP : S_RUN);
        chk("lap1_hold", {1'b0, HOLD}, {1'b0, LAP_EN});
        chk("lap1_ce", {1'b0, CE}, 2'd1);
        press(2, 8, 10);
        chk("lap2_state", state, S_RUN);
        chk("lap2_hold", {1'b0, HOLD}, 2'd0);

        // Back to IDLE, then start and clear together: start wins, no CLR.
        press(0, 8, 10);
        press(1, 8, 10);
        chk("idle_state", state, S_IDLE);
        btn_start = 1'b1;
        btn_clear = 1'b1;
        clr_seen  = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            clr_seen = clr_seen | CLR;
        end
        chk("simul_noclr", {1'b0, clr_seen}, 2'd0);
        chk("simul_state", state, S_RUN);
        btn_start = 1'b0;
        btn_clear = 1'b0;
        ticks(10);

        // Reset in the middle of a CLR pulse.
        press(0, 8, 10);
        btn_clear = 1'b1;
        ticks(8);
        chk("midclr_on", {1'b0, CLR}, 2'd1);
        R = 1'b1;
        model_reset();
        #1;
        chk("rstclr_clr", {1'b0, CLR}, 2'd0);
        chk("rstclr_state", state, S_IDLE);
        chk("rstclr_ce", {1'b0, CE}, 2'd0);
        btn_clear = 1'b0;
        btn_start = 1'b1;
        ticks(3);
        #3;
        // Start held across reset release: one event, state RUN on edge 7.
        R = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) chk("hold_rel_pre", state, S_IDLE);
            if (k == 7) chk("hold_rel", state, S_RUN);
        end
        ticks(20);
        chk("hold_rel_once", state, S_RUN);
        btn_start = 1'b0;
        ticks(10);

`ifdef STOPWATCH_LAP_EN
        // Reset while in LAP.
        press(2, 8, 10);
        chk("lap_pre_rst", state, S_LAP);
        #2;
        R = 1'b1;
        model_reset();
        #1;
        chk("lap_rst_state", state, S_IDLE);
        chk("lap_rst_hold", {1'b0, HOLD}, 2'd0);
        ticks(2);
        R = 1'b0;
        ticks(3);
`endif

        // Randomized segments of bouncy levels with occasional resets.
        for (int b = 0; b < 3; b++) begin
            rem[b] = 0;
            lvl[b] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    lvl[b] = 1'($urandom_range(0, 1));
                    rem[b] = $urandom_range(1, 12);
                end
                rem[b]--;
            end
            btn_start = lvl[0];
            btn_clear = lvl[1];
            btn_lap   = lvl[2];
            if ($urandom_range(0, 399) == 0) begin
                R = 1'b1;
                model_reset();
                #1;
                chk("rnd_rst_state", state, S_IDLE);
                tick();
                R = 1'b0;
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
